// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: owns the program counter, fetches one word per
// req/ack handshake and delivers it to the instruction register as a one-cycle load.
module inst_fetch #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int RESET_PC = 0,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_load,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        LOAD,
        ERR
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_req_reg, mem_req_next;
    logic              ir_load_reg, ir_load_next;
    logic [DATA_W-1:0] ir_data_reg, ir_data_next;
    logic              busy_reg, busy_next;
    logic              fetch_err_reg, fetch_err_next;
    logic [CNT_W-1:0]  wait_reg, wait_next;
    logic              flush_reg, flush_next;
    logic              start_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            pc_reg        <= ADDR_W'(RESET_PC);
            mem_addr_reg  <= ADDR_W'(RESET_PC);
            mem_req_reg   <= 1'b0;
            ir_load_reg   <= 1'b0;
            ir_data_reg   <= '0;
            busy_reg      <= 1'b0;
            fetch_err_reg <= 1'b0;
            wait_reg      <= '0;
            flush_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            mem_addr_reg  <= mem_addr_next;
            mem_req_reg   <= mem_req_next;
            ir_load_reg   <= ir_load_next;
            ir_data_reg   <= ir_data_next;
            busy_reg      <= busy_next;
            fetch_err_reg <= fetch_err_next;
            wait_reg      <= wait_next;
            flush_reg     <= flush_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        mem_addr_next  = mem_addr_reg;
        mem_req_next   = mem_req_reg;
        ir_load_next   = 1'b0;
        ir_data_next   = ir_data_reg;
        busy_next      = busy_reg;
        fetch_err_next = fetch_err_reg;
        wait_next      = wait_reg;
        flush_next     = flush_reg;
        start_req      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (branch_valid) begin
                    pc_next = branch_target;
                end else if (fetch_en) begin
                    start_req = 1'b1;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_next = 1'b0;
                    busy_next    = 1'b0;
                    flush_next   = 1'b0;
                    if (branch_valid || flush_reg) begin
                        // Word belongs to the abandoned path; pc already points at the target.
                        if (branch_valid) begin
                            pc_next = branch_target;
                        end
                        state_next = IDLE;
                    end else begin
                        ir_data_next = mem_rdata;
                        ir_load_next = 1'b1;
                        pc_next      = pc_reg + ADDR_W'(1);
                        state_next   = LOAD;
                    end
                end else begin
                    if (branch_valid) begin
                        pc_next    = branch_target;
                        flush_next = 1'b1;
                    end
                    if (wait_reg == CNT_W'(MAX_WAIT - 1)) begin
                        mem_req_next   = 1'b0;
                        busy_next      = 1'b0;
                        fetch_err_next = 1'b1;
                        flush_next     = 1'b0;
                        state_next     = ERR;
                    end else begin
                        wait_next = wait_reg + CNT_W'(1);
                    end
                end
            end
            LOAD: begin
                if (branch_valid) begin
                    pc_next    = branch_target;
                    state_next = IDLE;
                end else if (fetch_en) begin
                    start_req = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            ERR: begin
                if (branch_valid) begin
                    pc_next        = branch_target;
                    fetch_err_next = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (start_req) begin
            mem_addr_next = pc_reg;
            mem_req_next  = 1'b1;
            busy_next     = 1'b1;
            wait_next     = '0;
            state_next    = REQ;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_addr  = mem_addr_reg;
    assign ir_load   = ir_load_reg;
    assign ir_data   = ir_data_reg;
    assign pc        = pc_reg;
    assign busy      = busy_reg;
    assign fetch_err = fetch_err_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a behavioural memory answers requests and
// every ir_load is matched against the words the stimulus expects to arrive.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_en = 1'b0;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = '0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        ir_load;
    logic [15:0] ir_data;
    logic [15:0] pc;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;
    int load_cnt = 0;
    int ack_delay = 1;
    bit ack_en = 1'b1;
    logic [15:0] mem [0:65535];
    logic [15:0] exp_q [$];

    inst_fetch dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .branch_valid(branch_valid),
        .branch_target(branch_target), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_load(ir_load), .ir_data(ir_data),
        .pc(pc), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    // Memory model: ack arrives in the ack_delay-th cycle of mem_req.
    initial begin
        int req_cnt;
        req_cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && ack_en) begin
                if (req_cnt >= ack_delay - 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    mem_ack = 1'b0;
                end
                req_cnt++;
            end else begin
                mem_ack = 1'b0;
                req_cnt = 0;
            end
        end
    end

    // Scoreboard consumer.
    initial begin
        logic [15:0] exp_word;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && ir_load === 1'b1) begin
                load_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_load", 32'(ir_data), 32'hDEAD_0000);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("ir_data", 32'(ir_data), 32'(exp_word));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic pulse_fetch();
        fetch_en = 1'b1;
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    task automatic pulse_branch(input logic [15:0] target);
        branch_valid = 1'b1;
        branch_target = target;
        @(negedge clk);
        branch_valid = 1'b0;
    endtask

    task automatic wait_loads(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (load_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (load_cnt < target) check(tag, 32'(load_cnt), 32'(target));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) check(tag, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [5:0] load_pat;
        logic [5:0] req_pat;
        int cnt;
        int start_loads;

        for (int i = 0; i < 65536; i++) mem[i] = 16'(i ^ 16'h5A5A);
        mem[0] = 16'hA001;
        mem[1] = 16'hB002;
        mem[2] = 16'hC003;
        mem[3] = 16'h1234;
        mem[16'h0040] = 16'h4040;
        mem[16'hFFFF] = 16'hBEEF;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_ir_load", 32'(ir_load), 32'h0);
        check("rst_ir_data", 32'(ir_data), 32'h0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fetch_err", 32'(fetch_err), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Back-to-back zero-wait fetches: loads every other cycle.
        ack_delay = 1;
        exp_q.push_back(16'hA001);
        exp_q.push_back(16'hB002);
        exp_q.push_back(16'hC003);
        load_pat = 6'b101010;
        req_pat  = 6'b010101;
        fetch_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("seq_ir_load[%0d]", i), 32'(ir_load), 32'(load_pat[i]));
            check($sformatf("seq_mem_req[%0d]", i), 32'(mem_req), 32'(req_pat[i]));
            if (i == 4) fetch_en = 1'b0;
        end
        check("seq_pc", 32'(pc), 32'h3);
        @(negedge clk);
        check("seq_loads", 32'(load_cnt), 32'h3);

        // Three-cycle memory.
        ack_delay = 3;
        exp_q.push_back(16'h1234);
        pulse_fetch();
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) begin
                cnt++;
                check("slow_mem_addr", 32'(mem_addr), 32'h3);
            end
            @(negedge clk);
        end
        check("slow_busy_cycles", 32'(cnt), 32'h3);
        check("slow_loads", 32'(load_cnt), 32'h4);
        check("slow_pc", 32'(pc), 32'h4);

        // Branch while a request is in flight: word is flushed.
        ack_delay = 4;
        start_loads = load_cnt;
        pulse_fetch();
        pulse_branch(16'h0040);
        check("flush_pc", 32'(pc), 32'h40);
        check("flush_req_held", 32'(mem_req), 32'h1);
        check("flush_addr_held", 32'(mem_addr), 32'h4);
        wait_idle(20, "flush_idle_timeout");
        repeat (2) @(negedge clk);
        check("flush_no_load", 32'(load_cnt), 32'(start_loads));
        check("flush_pc_after", 32'(pc), 32'h40);
        ack_delay = 1;
        exp_q.push_back(16'h4040);
        pulse_fetch();
        check("redirect_addr", 32'(mem_addr), 32'h40);
        wait_loads(start_loads + 1, 10, "redirect_load_timeout");
        @(negedge clk);
        check("redirect_pc", 32'(pc), 32'h41);

        // pc wrap-around.
        pulse_branch(16'hFFFF);
        check("wrap_pc_before", 32'(pc), 32'hFFFF);
        exp_q.push_back(16'hBEEF);
        start_loads = load_cnt;
        pulse_fetch();
        wait_loads(start_loads + 1, 10, "wrap_load_timeout");
        check("wrap_pc", 32'(pc), 32'h0);
        @(negedge clk);

        // Timeout into ERR, then branch out.
        ack_en = 1'b0;
        pulse_fetch();
        cnt = 0;
        for (int i = 0; i < 40 && fetch_err !== 1'b1; i++) begin
            if (mem_req === 1'b1) cnt++;
            @(negedge clk);
        end
        check("to_req_cycles", 32'(cnt), 32'd15);
        check("to_fetch_err", 32'(fetch_err), 32'h1);
        check("to_mem_req", 32'(mem_req), 32'h0);
        check("to_pc", 32'(pc), 32'h0);
        fetch_en = 1'b1;
        repeat (3) @(negedge clk);
        fetch_en = 1'b0;
        check("err_ignores_fetch", 32'(mem_req), 32'h0);
        check("err_sticky", 32'(fetch_err), 32'h1);
        ack_en = 1'b1;
        pulse_branch(16'h0010);
        check("err_cleared", 32'(fetch_err), 32'h0);
        check("err_pc", 32'(pc), 32'h10);
        check("err_busy", 32'(busy), 32'h0);

        // Asynchronous reset in the middle of a request.
        ack_delay = 5;
        start_loads = load_cnt;
        pulse_fetch();
        @(negedge clk);
        check("arst_pre_req", 32'(mem_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'h0);
        check("arst_pc", 32'(pc), 32'h0);
        check("arst_ir_data", 32'(ir_data), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        check("arst_no_load", 32'(load_cnt), 32'(start_loads));
        check("arst_idle", 32'(busy), 32'h0);

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
